// File: rtl/uart_rx_controller.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_controller
// Description : Start-bit detection, mid-bit shift strobes, stop-bit check
//               and character-ready handshake for an oversampled UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_controller #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic       sr_clk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       char_ack,
  output logic       shift_en,
  output logic [3:0] bit_index,
  output logic       busy,
  output logic       char_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int              c_CW       = $clog2(OVERSAMPLE);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(OVERSAMPLE - 1);
  localparam logic [c_CW-1:0] c_CNT_HALF = c_CW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [3:0]      c_BIT_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic [3:0]      r_bit_idx;
  logic            r_char_ready;
  logic            r_frame_err;
  logic            r_overrun;
  logic            w_cnt_last;

  assign w_cnt_last = (r_cnt == c_CNT_LAST);

  always_ff @(posedge sr_clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_char_ready <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!serial_in) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        // Re-sample at the middle of the start bit to reject glitches.
        S_START: begin
          if (r_cnt == c_CNT_HALF) begin
            r_cnt <= '0;
            if (!serial_in) begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        S_DATA: begin
          r_cnt <= r_cnt + c_CNT_ONE;
          if (w_cnt_last) begin
            r_bit_idx <= r_bit_idx + 4'd1;
            if (r_bit_idx == c_BIT_LAST) begin
              r_state <= S_STOP;
              r_cnt   <= '0;
            end
          end
        end
        S_STOP: begin
          r_cnt <= r_cnt + c_CNT_ONE;
          if (w_cnt_last) begin
            r_state      <= S_HOLD;
            r_char_ready <= serial_in;
            r_frame_err  <= !serial_in;
          end
        end
        S_HOLD: begin
          if (char_ack) begin
            r_state      <= S_IDLE;
            r_bit_idx    <= '0;
            r_char_ready <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
          end else if (!serial_in) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign shift_en   = (r_state == S_DATA) && w_cnt_last;
  assign busy       = (r_state != S_IDLE);
  assign bit_index  = r_bit_idx;
  assign char_ready = r_char_ready;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_controller
// Description : Directed and randomized frames against a timeline model of the
//               receive controller, compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_controller;

  localparam int OS        = 16;
  localparam int DB        = 8;
  localparam int HALF      = OS / 2;
  localparam int STOP_EDGE = HALF + OS * (DB + 1);

  logic       sr_clk    = 1'b0;
  logic       reset     = 1'b1;
  logic       serial_in = 1'b1;
  logic       char_ack  = 1'b0;
  logic       shift_en, busy, char_ready, frame_err, overrun;
  logic [3:0] bit_index;

  uart_rx_controller #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .sr_clk    (sr_clk),
    .reset     (reset),
    .serial_in (serial_in),
    .char_ack  (char_ack),
    .shift_en  (shift_en),
    .bit_index (bit_index),
    .busy      (busy),
    .char_ready(char_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 sr_clk = ~sr_clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 receiving (m_e = edges since start detect), 2 holding.
  int   m_mode = 0;
  int   m_e    = 0;
  logic m_rdy  = 1'b0;
  logic m_fe   = 1'b0;
  logic m_ov   = 1'b0;

  always @(posedge sr_clk) begin
    if (reset) begin
      m_mode <= 0; m_e <= 0; m_rdy <= 1'b0; m_fe <= 1'b0; m_ov <= 1'b0;
    end else if (m_mode == 0) begin
      if (!serial_in) begin
        m_mode <= 1;
        m_e    <= 0;
      end
    end else if (m_mode == 1) begin
      if (m_e + 1 == HALF && serial_in) begin
        m_mode <= 0;
      end else if (m_e + 1 == STOP_EDGE) begin
        m_mode <= 2;
        m_rdy  <= serial_in;
        m_fe   <= !serial_in;
      end else begin
        m_e <= m_e + 1;
      end
    end else begin
      if (char_ack) begin
        m_mode <= 0; m_rdy <= 1'b0; m_fe <= 1'b0; m_ov <= 1'b0;
      end else if (!serial_in) begin
        m_ov <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] exp_shift();
    int n;
    if (m_mode != 1) return 0;
    n = m_e + 1;
    return ((n >= HALF + OS) && (n <= HALF + OS * DB) && ((n - HALF) % OS == 0)) ? 1 : 0;
  endfunction

  function automatic logic [31:0] exp_bidx();
    int b;
    if (m_mode == 0) return 0;
    if (m_mode == 2) return DB;
    if (m_e < HALF) return 0;
    b = (m_e - HALF) / OS;
    return (b > DB) ? DB : b;
  endfunction

  logic chk_en = 1'b0;

  always @(negedge sr_clk) begin
    if (chk_en) begin
      check("shift_en",   shift_en,   exp_shift());
      check("bit_index",  bit_index,  exp_bidx());
      check("busy",       busy,       (m_mode != 0) ? 1 : 0);
      check("char_ready", char_ready, m_rdy);
      check("frame_err",  frame_err,  m_fe);
      check("overrun",    overrun,    m_ov);
    end
  end

  // Edge counter, strobe log and a shift register fed by shift_en.
  int          cyc    = 0;
  int          npulse = 0;
  int          pulse_edge[$];
  logic [DB-1:0] cap  = '0;

  always @(posedge sr_clk) begin
    cyc <= cyc + 1;
    if (shift_en === 1'b1) begin
      npulse <= npulse + 1;
      pulse_edge.push_back(cyc);
      cap <= {serial_in, cap[DB-1:1]};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sr_clk);
    #2;
  endtask

  task automatic pulse_ack();
    char_ack = 1'b1;
    tick(1);
    char_ack = 1'b0;
  endtask

  // Drives one frame cycle by cycle; edge 0 is the first edge that sees the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stopv, input int rst_at, input int ack_at);
    for (int e = 0; e < OS * (DB + 2); e++) begin
      if (e < OS)             serial_in = 1'b0;
      else if (e < OS*(DB+1)) serial_in = d[e/OS - 1];
      else                    serial_in = stopv;
      char_ack = (e == ack_at);
      if (e == rst_at) begin
        reset = 1'b1; serial_in = 1'b1; char_ack = 1'b0;
        tick(1);
        reset = 1'b0;
        return;
      end
      tick(1);
    end
    serial_in = 1'b1;
    char_ack  = 1'b0;
  endtask

  int exp_edges[8] = '{24, 40, 56, 72, 88, 104, 120, 136};

  initial begin
    int t0, p0, q0, kind, len;
    logic [7:0] d;
    logic stopv;

    tick(1);
    chk_en = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_bidx", bit_index, 0);
    check("rst_flags", {char_ready, frame_err, overrun}, 0);
    p0 = npulse;
    tick(50);
    check("idle_pulses", npulse - p0, 0);
    check("idle_busy", busy, 0);

    // 0xA5 with good stop bit: strobe timing and captured data.
    t0 = cyc; p0 = npulse; q0 = pulse_edge.size();
    send_frame(8'hA5, 1'b1, -1, -1);
    check("a5_pulses", npulse - p0, 8);
    for (int k = 0; k < 8; k++) check("a5_edge", pulse_edge[q0 + k] - t0, exp_edges[k]);
    check("a5_data", cap, 8'hA5);
    check("a5_ready", char_ready, 1);
    check("a5_ferr", frame_err, 0);
    check("a5_bidx", bit_index, 8);
    pulse_ack();
    check("a5_ack_ready", char_ready, 0);
    check("a5_ack_bidx", bit_index, 0);
    check("a5_ack_busy", busy, 0);

    // Short glitch aborts in START.
    p0 = npulse;
    serial_in = 1'b0; tick(4);
    serial_in = 1'b1; tick(20);
    check("glitch_pulses", npulse - p0, 0);
    check("glitch_busy", busy, 0);
    check("glitch_flags", {char_ready, frame_err, overrun}, 0);

    // Bad stop bit.
    send_frame(8'hA5, 1'b0, -1, -1);
    check("ferr_set", frame_err, 1);
    check("ferr_ready", char_ready, 0);
    pulse_ack();
    check("ferr_clear", frame_err, 0);

    // Second start while holding an unacknowledged character.
    send_frame(8'h3C, 1'b1, -1, -1);
    tick(3);
    p0 = npulse;
    serial_in = 1'b0; tick(5);
    serial_in = 1'b1; tick(10);
    check("ovr_set", overrun, 1);
    check("ovr_busy", busy, 1);
    check("ovr_pulses", npulse - p0, 0);
    check("ovr_data", cap, 8'h3C);
    pulse_ack();
    check("ovr_clear", {char_ready, frame_err, overrun}, 0);

    // Reset in the middle of the data bits, then a clean frame.
    send_frame(8'h5A, 1'b1, 70, -1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_bidx", bit_index, 0);
    p0 = npulse;
    tick(30);
    check("mid_rst_pulses", npulse - p0, 0);
    send_frame(8'hC3, 1'b1, -1, -1);
    check("post_rst_data", cap, 8'hC3);
    check("post_rst_ready", char_ready, 1);
    pulse_ack();

    // Randomized mix of frames, glitches, resets, stray acks and overruns.
    for (int it = 0; it < 30; it++) begin
      d     = 8'($urandom);
      stopv = ($urandom_range(0, 3) != 0);
      kind  = $urandom_range(0, 5);
      if (kind == 0) begin
        len = $urandom_range(1, 7);
        serial_in = 1'b0; tick(len);
        serial_in = 1'b1; tick(12);
      end else if (kind == 1) begin
        send_frame(d, stopv, $urandom_range(0, OS*(DB+2) - 1), -1);
      end else begin
        send_frame(d, stopv, -1, (kind == 3) ? $urandom_range(0, STOP_EDGE - 2) : -1);
        check("rand_data", cap, d);
        if (kind == 2) begin
          tick($urandom_range(1, 4));
          serial_in = 1'b0; tick($urandom_range(1, 4));
          serial_in = 1'b1;
        end
      end
      tick($urandom_range(1, 6));
      pulse_ack();
      tick($urandom_range(1, 10));
    end

    tick(5);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
